thumb_issue_stage: RTL and testbench

//  Decode/operand-fetch stage sitting directly upstream of the ALU. Accepts 16-bit Thumb

---
 rtl/alu_pkg.sv | 33 +++
 rtl/thumb_issue_stage_decoder.sv | 94 +++++++++
 rtl/thumb_issue_stage.sv | 115 +++++++++++
 tb/tb_thumb_issue_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: micro-op encodings, datapath widths and the decoded
// instruction record passed from the Thumb decoder to the issue stage.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 8;
  localparam int unsigned RAW   = 3;  // register address width
  localparam int unsigned UOPW  = 5;

  localparam logic [UOPW-1:0] UOP_NOP = 5'd0;
  localparam logic [UOPW-1:0] UOP_ADD = 5'd1;
  localparam logic [UOPW-1:0] UOP_SUB = 5'd2;
  localparam logic [UOPW-1:0] UOP_AND = 5'd3;
  localparam logic [UOPW-1:0] UOP_XOR = 5'd4;
  localparam logic [UOPW-1:0] UOP_CMP = 5'd5;
  localparam logic [UOPW-1:0] UOP_LSL = 5'd6;
  localparam logic [UOPW-1:0] UOP_LSR = 5'd7;
  localparam logic [UOPW-1:0] UOP_MOV = 5'd8;

  typedef struct packed {
    logic [UOPW-1:0] uop;
    logic [RAW-1:0]  src_a;
    logic [RAW-1:0]  src_b;
    logic            use_a;
    logic            use_b;
    logic [7:0]      imm;
    logic            use_imm;
    logic [RAW-1:0]  dest;
    logic            wr_en;
    logic            undef;
  } dec_t;

endpackage

// File: rtl/thumb_issue_stage_decoder.sv
// thumb_decoder: combinational decode of the supported 16-bit Thumb
// data-processing subset.
//   instr_i : raw Thumb instruction
//   dec_o   : {uop, src_a, src_b, use_a, use_b, imm, use_imm, dest, wr_en, undef}
// Anything outside the subset decodes to a NOP with undef set and no register use.
module thumb_decoder
  import alu_pkg::*;
(
  input  logic [15:0] instr_i,
  output dec_t        dec_o
);

  always_comb begin
    dec_o     = '0;
    dec_o.uop = UOP_NOP;
    casez (instr_i)
      16'b0000_0???_????_????,
      16'b0000_1???_????_????: begin
        dec_o.uop     = instr_i[11] ? UOP_LSR : UOP_LSL;
        dec_o.src_a   = instr_i[5:3];
        dec_o.use_a   = 1'b1;
        dec_o.imm     = {3'b000, instr_i[10:6]};
        dec_o.use_imm = 1'b1;
        dec_o.dest    = instr_i[2:0];
        dec_o.wr_en   = 1'b1;
      end
      16'b0001_10??_????_????: begin
        dec_o.uop   = instr_i[9] ? UOP_SUB : UOP_ADD;
        dec_o.src_a = instr_i[5:3];
        dec_o.use_a = 1'b1;
        dec_o.src_b = instr_i[8:6];
        dec_o.use_b = 1'b1;
        dec_o.dest  = instr_i[2:0];
        dec_o.wr_en = 1'b1;
      end
      16'b0001_11??_????_????: begin
        dec_o.uop     = instr_i[9] ? UOP_SUB : UOP_ADD;
        dec_o.src_a   = instr_i[5:3];
        dec_o.use_a   = 1'b1;
        dec_o.imm     = {5'b00000, instr_i[8:6]};
        dec_o.use_imm = 1'b1;
        dec_o.dest    = instr_i[2:0];
        dec_o.wr_en   = 1'b1;
      end
      16'b0010_0???_????_????: begin
        dec_o.uop     = UOP_MOV;
        dec_o.imm     = instr_i[7:0];
        dec_o.use_imm = 1'b1;
        dec_o.dest    = instr_i[10:8];
        dec_o.wr_en   = 1'b1;
      end
      16'b0010_1???_????_????,
      16'b0011_0???_????_????,
      16'b0011_1???_????_????: begin
        // [12:11]: 01 CMP, 10 ADD, 11 SUB; all read Rd against imm8
        unique case (instr_i[12:11])
          2'b01:   dec_o.uop = UOP_CMP;
          2'b10:   dec_o.uop = UOP_ADD;
          default: dec_o.uop = UOP_SUB;
        endcase
        dec_o.src_a   = instr_i[10:8];
        dec_o.use_a   = 1'b1;
        dec_o.imm     = instr_i[7:0];
        dec_o.use_imm = 1'b1;
        dec_o.dest    = instr_i[10:8];
        dec_o.wr_en   = (instr_i[12:11] != 2'b01);
      end
      16'b0100_00??_????_????: begin
        dec_o.src_a = instr_i[2:0];
        dec_o.use_a = 1'b1;
        dec_o.src_b = instr_i[5:3];
        dec_o.use_b = 1'b1;
        dec_o.dest  = instr_i[2:0];
        dec_o.wr_en = 1'b1;
        case (instr_i[9:6])
          4'b0000: dec_o.uop = UOP_AND;
          4'b0001: dec_o.uop = UOP_XOR;
          4'b0010: dec_o.uop = UOP_LSL;
          4'b0011: dec_o.uop = UOP_LSR;
          4'b1010: begin
            dec_o.uop   = UOP_CMP;
            dec_o.wr_en = 1'b0;
          end
          default: begin
            dec_o       = '0;
            dec_o.undef = 1'b1;
          end
        endcase
      end
      default: dec_o.undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/thumb_issue_stage.sv
// thumb_issue_stage: decode/operand-fetch stage in front of the ALU.
// Reads an internal register file, blocks RAW/WAW hazards against in-flight
// writebacks with a pending-bit scoreboard and presents a registered bundle.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_instr/in_ready    : instruction input handshake
//   ex_valid/ex_ready             : bundle output handshake
//   lhs, rhs, uop, dest, wr_en, undef : issued bundle
//   wb_en, wb_addr, wb_data       : writeback port
module thumb_issue_stage #(
  parameter int unsigned NREGS = alu_pkg::NREGS,
  parameter int unsigned XLEN  = alu_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  output logic                     in_ready,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [XLEN-1:0]          lhs,
  output logic [XLEN-1:0]          rhs,
  output logic [alu_pkg::UOPW-1:0] uop,
  output logic [alu_pkg::RAW-1:0]  dest,
  output logic                     wr_en,
  output logic                     undef,
  input  logic                     wb_en,
  input  logic [alu_pkg::RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0]          wb_data
);
  import alu_pkg::*;

  dec_t dec;

  thumb_decoder u_dec (
    .instr_i (in_instr),
    .dec_o   (dec)
  );

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  logic             ex_valid_q;
  logic [XLEN-1:0]  lhs_q, lhs_d;
  logic [XLEN-1:0]  rhs_q, rhs_d;
  logic [UOPW-1:0]  uop_q;
  logic [RAW-1:0]   dest_q;
  logic             wr_en_q, undef_q;

  logic fwd_a, fwd_b, fwd_d, stall, xfer;

  // A pending register being written back this cycle is not a hazard: its
  // value is taken straight from wb_data.
  assign fwd_a = wb_en && (wb_addr == dec.src_a);
  assign fwd_b = wb_en && (wb_addr == dec.src_b);
  assign fwd_d = wb_en && (wb_addr == dec.dest);

  assign stall = (dec.use_a && pend_q[dec.src_a] && !fwd_a) ||
                 (dec.use_b && pend_q[dec.src_b] && !fwd_b) ||
                 (dec.wr_en && pend_q[dec.dest]  && !fwd_d);

  assign in_ready = !stall && (!ex_valid_q || ex_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    lhs_d = '0;
    if (dec.use_a) lhs_d = fwd_a ? wb_data : rf_q[dec.src_a];
    rhs_d = '0;
    if (dec.use_imm)    rhs_d = XLEN'(dec.imm);
    else if (dec.use_b) rhs_d = fwd_b ? wb_data : rf_q[dec.src_b];
  end

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (wb_en) pend_d[wb_addr] = 1'b0;
    if (xfer && dec.wr_en) pend_d[dec.dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      pend_q     <= '0;
      ex_valid_q <= 1'b0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      uop_q      <= UOP_NOP;
      dest_q     <= '0;
      wr_en_q    <= 1'b0;
      undef_q    <= 1'b0;
    end else begin
      if (wb_en) rf_q[wb_addr] <= wb_data;
      pend_q <= pend_d;
      if (xfer) begin
        ex_valid_q <= 1'b1;
        lhs_q      <= lhs_d;
        rhs_q      <= rhs_d;
        uop_q      <= dec.uop;
        dest_q     <= dec.dest;
        wr_en_q    <= dec.wr_en;
        undef_q    <= dec.undef;
      end else if (ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid = ex_valid_q;
  assign lhs      = lhs_q;
  assign rhs      = rhs_q;
  assign uop      = uop_q;
  assign dest     = dest_q;
  assign wr_en    = wr_en_q;
  assign undef    = undef_q;

endmodule

// File: tb/tb_thumb_issue_stage.sv
// Bench for thumb_issue_stage: directed instruction vectors, a cycle-level
// architectural model checked every cycle, plus hand-computed literal checks.
module tb_thumb_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] lhs, rhs;
  logic [4:0]  uop;
  logic [2:0]  dest;
  logic        wr_en, undef;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  always #5 clk = ~clk;

  thumb_issue_stage #(.NREGS(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .lhs(lhs), .rhs(rhs), .uop(uop), .dest(dest), .wr_en(wr_en),
    .undef(undef), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  typedef struct {
    int uop; bit ua; int ra; bit ub; int rb; bit ui; int imm;
    bit wr; int dst; bit und;
  } mdec_t;

  function automatic mdec_t mdecode(logic [15:0] i);
    mdec_t d;
    int op5, op4;
    d = '{default: 0};
    op5 = int'(i[15:11]);
    op4 = int'(i[9:6]);
    if (op5 <= 1) begin                     // shift by imm5
      d.uop = (op5 == 0) ? 6 : 7;
      d.ua = 1; d.ra = int'(i[5:3]); d.ui = 1; d.imm = int'(i[10:6]);
      d.wr = 1; d.dst = int'(i[2:0]);
    end else if (op5 == 3) begin            // add/sub reg or imm3
      d.uop = i[9] ? 2 : 1;
      d.ua = 1; d.ra = int'(i[5:3]);
      if (i[10]) begin d.ui = 1; d.imm = int'(i[8:6]); end
      else begin d.ub = 1; d.rb = int'(i[8:6]); end
      d.wr = 1; d.dst = int'(i[2:0]);
    end else if (op5 == 4) begin            // MOV imm8
      d.uop = 8; d.ui = 1; d.imm = int'(i[7:0]); d.wr = 1; d.dst = int'(i[10:8]);
    end else if (op5 >= 5 && op5 <= 7) begin // CMP/ADD/SUB imm8
      d.uop = (op5 == 5) ? 5 : (op5 == 6) ? 1 : 2;
      d.ua = 1; d.ra = int'(i[10:8]); d.ui = 1; d.imm = int'(i[7:0]);
      d.wr = (op5 != 5); d.dst = int'(i[10:8]);
    end else if (i[15:10] == 6'b010000 &&
                 (op4 == 0 || op4 == 1 || op4 == 2 || op4 == 3 || op4 == 10)) begin
      d.uop = (op4 == 0) ? 3 : (op4 == 1) ? 4 : (op4 == 2) ? 6 : (op4 == 3) ? 7 : 5;
      d.ua = 1; d.ra = int'(i[2:0]); d.ub = 1; d.rb = int'(i[5:3]);
      d.wr = (op4 != 10); d.dst = int'(i[2:0]);
    end else begin
      d.und = 1;
    end
    return d;
  endfunction

  logic [31:0] m_regs [8];
  bit          m_pend [8];
  bit          m_valid;
  logic [31:0] m_lhs, m_rhs;
  int          m_uop, m_dst;
  bit          m_wr, m_und;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin m_regs[k] = '0; m_pend[k] = 0; end
    m_valid = 0; m_lhs = '0; m_rhs = '0; m_uop = 0; m_dst = 0; m_wr = 0; m_und = 0;
  endtask

  task automatic model_step();
    mdec_t d;
    bit fa, fb, fd, stl, exp_rdy;
    logic [31:0] a, b;
    d  = mdecode(in_instr);
    fa = wb_en && (int'(wb_addr) == d.ra);
    fb = wb_en && (int'(wb_addr) == d.rb);
    fd = wb_en && (int'(wb_addr) == d.dst);
    stl = (d.ua && m_pend[d.ra] && !fa) || (d.ub && m_pend[d.rb] && !fb) ||
          (d.wr && m_pend[d.dst] && !fd);
    exp_rdy = !stl && (!m_valid || ex_ready);
    chk("m_in_ready", in_ready, exp_rdy);
    chk("m_ex_valid", ex_valid, m_valid);
    if (m_valid) begin
      chk("m_lhs", lhs, m_lhs);
      chk("m_rhs", rhs, m_rhs);
      chk("m_uop", uop, m_uop);
      chk("m_wr_en", wr_en, m_wr);
      chk("m_undef", undef, m_und);
      if (m_wr) chk("m_dest", dest, m_dst);
    end
    if (rst) begin
      model_reset();
      return;
    end
    a = d.ua ? (fa ? wb_data : m_regs[d.ra]) : 32'd0;
    b = d.ui ? 32'(d.imm) : d.ub ? (fb ? wb_data : m_regs[d.rb]) : 32'd0;
    if (wb_en) begin m_regs[wb_addr] = wb_data; m_pend[wb_addr] = 0; end
    if (in_valid && exp_rdy) begin
      if (d.wr) m_pend[d.dst] = 1;
      m_valid = 1; m_lhs = a; m_rhs = b; m_uop = d.uop;
      m_dst = d.dst; m_wr = d.wr; m_und = d.und;
    end else if (ex_ready) begin
      m_valid = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #4;
      if (chk_en) model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(bit v, logic [15:0] ins, bit er, bit we, logic [2:0] wa,
                      logic [31:0] wd, bit r = 0);
    @(negedge clk);
    #1;
    rst = r; in_valid = v; in_instr = ins; ex_ready = er;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
  endtask

  typedef struct { logic [15:0] ins; logic [31:0] wbd; } vec_t;
  vec_t vecs [9];

  initial begin
    mdec_t d;
    vecs[0] = '{16'h1A88, 32'h0000_1000};  // SUBS R0,R1,R2
    vecs[1] = '{16'h4008, 32'h0000_2000};  // ANDS R0,R1
    vecs[2] = '{16'h4091, 32'h0000_3000};  // LSLS R1,R2
    vecs[3] = '{16'h42A2, 32'h0000_4000};  // CMP R2,R4
    vecs[4] = '{16'h3E10, 32'h0000_5000};  // SUBS R6,#0x10
    vecs[5] = '{16'h3501, 32'h0000_6000};  // ADDS R5,#1
    vecs[6] = '{16'h0100, 32'h0000_7000};  // LSLS R0,R0,#4
    vecs[7] = '{16'h1000, 32'h0000_8000};  // ASR imm: unsupported
    vecs[8] = '{16'h4100, 32'h0000_9000};  // ADC: unsupported

    step(0, 16'h0, 1, 0, 0, 0, 1);
    chk_en = 1'b1;
    step(0, 16'h0, 1, 0, 0, 0, 1);
    step(0, 16'h0, 1, 0, 0, 0);
    chk("rst_in_ready", in_ready, 1); chk("rst_ex_valid", ex_valid, 0);
    chk("rst_lhs", lhs, 0); chk("rst_rhs", rhs, 0); chk("rst_uop", uop, 0);
    chk("rst_dest", dest, 0); chk("rst_wr_en", wr_en, 0); chk("rst_undef", undef, 0);

    // MOVS R1,#5 then ADDS R2,R1,#3 after writeback
    step(1, 16'h2105, 1, 0, 0, 0);
    step(0, 16'h0, 1, 1, 3'd1, 32'd5);
    chk("mov_valid", ex_valid, 1); chk("mov_uop", uop, 8); chk("mov_lhs", lhs, 0);
    chk("mov_rhs", rhs, 5); chk("mov_dest", dest, 1); chk("mov_wr", wr_en, 1);
    step(1, 16'h1CCA, 1, 0, 0, 0);
    chk("add_ready", in_ready, 1);
    step(0, 16'h0, 1, 1, 3'd2, 32'd8);
    chk("add_uop", uop, 1); chk("add_lhs", lhs, 5); chk("add_rhs", rhs, 3);
    chk("add_dest", dest, 2);

    // RAW stall, released by same-cycle writeback
    step(1, 16'h2105, 1, 0, 0, 0);
    step(1, 16'h1CCA, 1, 0, 0, 0);
    chk("raw_stall", in_ready, 0);
    step(1, 16'h1CCA, 1, 1, 3'd1, 32'h77);
    chk("raw_release", in_ready, 1);

    // Backpressure
    step(1, 16'h2307, 0, 1, 3'd2, 32'h7A);
    chk("bp0_valid", ex_valid, 1); chk("bp0_lhs", lhs, 32'h77); chk("bp0_ready", in_ready, 0);
    for (int c = 0; c < 2; c++) begin
      step(1, 16'h2307, 0, 0, 0, 0);
      chk("bp_valid", ex_valid, 1); chk("bp_lhs", lhs, 32'h77);
      chk("bp_rhs", rhs, 3); chk("bp_ready", in_ready, 0);
    end
    step(1, 16'h2307, 1, 0, 0, 0);
    chk("bp_release", in_ready, 1);
    step(1, 16'h28FF, 1, 1, 3'd3, 32'd7);
    chk("mov3_uop", uop, 8); chk("mov3_rhs", rhs, 7); chk("mov3_dest", dest, 3);
    chk("cmp_ready", in_ready, 1);

    // CMP then LSRS R0,R1,#1
    step(1, 16'h0848, 1, 0, 0, 0);
    chk("cmp_uop", uop, 5); chk("cmp_wr", wr_en, 0); chk("cmp_rhs", rhs, 32'hFF);
    chk("cmp_lhs", lhs, 0); chk("lsr_ready", in_ready, 1);
    step(1, 16'hB000, 1, 1, 3'd0, 32'h3B);
    chk("lsr_uop", uop, 7); chk("lsr_lhs", lhs, 32'h77); chk("lsr_rhs", rhs, 1);
    chk("lsr_dest", dest, 0); chk("lsr_wr", wr_en, 1);

    // Undefined followed by EORS R0,R1 with no bubble
    step(1, 16'h4048, 1, 0, 0, 0);
    chk("undef_uop", uop, 0); chk("undef_flag", undef, 1); chk("undef_wr", wr_en, 0);
    chk("undef_lhs", lhs, 0); chk("undef_rhs", rhs, 0); chk("nobubble_ready", in_ready, 1);
    step(1, 16'h2105, 1, 0, 0, 0);
    chk("xor_valid", ex_valid, 1); chk("xor_uop", uop, 4); chk("xor_lhs", lhs, 32'h3B);
    chk("xor_rhs", rhs, 32'h77); chk("xor_undef", undef, 0);

    // Reset with a live bundle and R0/R1 pending; writeback during reset ignored
    step(0, 16'h0, 1, 1, 3'd1, 32'hDEAD, 1);
    chk("prerst_valid", ex_valid, 1); chk("prerst_uop", uop, 8);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ins;
      ins = 16'h1800 | 16'((2 * k + 1) << 6) | 16'((2 * k) << 3) | 16'(2 * k);
      step(1, ins, 1, 0, 0, 0);
      chk("postrst_ready", in_ready, 1);
      if (k == 0) chk("postrst_valid", ex_valid, 0);
      else begin chk("postrst_lhs", lhs, 0); chk("postrst_rhs", rhs, 0); end
    end
    step(0, 16'h0, 1, 1, 3'd0, 32'h11);
    chk("postrst_lhs3", lhs, 0); chk("postrst_rhs3", rhs, 0);
    step(0, 16'h0, 1, 1, 3'd2, 32'h22);
    step(0, 16'h0, 1, 1, 3'd4, 32'h44);
    step(0, 16'h0, 1, 1, 3'd6, 32'h66);
    step(0, 16'h0, 1, 1, 3'd7, 32'h5);   // not pending: plain write

    // Mixed vectors; each result written back on the following cycle
    foreach (vecs[i]) begin
      step(1, vecs[i].ins, 1, 0, 0, 0);
      d = mdecode(vecs[i].ins);
      step(0, 16'h0, 1, d.wr, 3'(d.dst), vecs[i].wbd);
      if (i == 0) begin
        chk("sub_uop", uop, 2); chk("sub_lhs", lhs, 0); chk("sub_rhs", rhs, 32'h22);
      end
    end
    step(0, 16'h0, 1, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
